mmio_joypad_ctrl: RTL
=====================

MMIO_JOYPAD_CTRL -- requirements
Module: mmio_joypad_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16384, number of consecutive stable clk cycles (about 3.9 ms at 4.16 MHz) before a button change is accepted; legal range 2..65535.
REQ-002 clk  in  1  system clock (clk_4mhz domain); the only clock.
REQ-003 rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-004 btn  in  8  raw board buttons, active-high, asynchronous: [7] start, [6] select, [5] B, [4] A, [3] down, [2] up, [1] left, [0] right.
REQ-005 bus_sel  in  1  MMU decode hit for 0xFF00 (P1); qualifies bus_we and bus_re.
REQ-006 bus_we  in  1  write strobe.
REQ-007 bus_re  in  1  read strobe.
REQ-008 bus_wdata  in  8  write data.
REQ-009 bus_rdata  out  8  read data.
REQ-010 joypad_irq  out  1  one-cycle interrupt request pulse; drives interrupts.joypad.

Function
REQ-011 Each btn bit SHALL pass through a 2-flop synchronizer before any other use; there is no combinational path from btn to any output.
REQ-012 Debounce is per bit: one counter and one accepted state db[i] per button.
- Counter clears whenever sync[i] == db[i].
- Otherwise it increments each cycle.
- When the counter reaches DEBOUNCE_CYCLES-1 while still differing, db[i] takes sync[i] on that edge and the counter clears.
REQ-013 Counters SHALL saturate and never wrap; width is clog2(DEBOUNCE_CYCLES).
REQ-014 Register sel[1:0] maps to P1[5:4]: sel[1] = P15 (action buttons), sel[0] = P14 (directions); both active-low.
REQ-015 On bus_sel & bus_we, sel SHALL load bus_wdata[5:4] on the next edge; bus_wdata[7:6] and [3:0] are ignored.
REQ-016 Combinational nibble nib[3:0]:
- Starts at 4'hF.
- If sel[0] == 0, clear bit k where db[k] = 1, for k = 0..3 (directions).
- If sel[1] == 0, clear bit k where db[k+4] = 1 (action buttons).
- Both groups selected: the clears are ORed.
- Neither group selected: nib = 4'hF.
REQ-017 P1 value = {2'b11, sel, nib}.
REQ-018 bus_rdata SHALL be registered with 1-cycle latency: on bus_sel & bus_re, bus_rdata <= P1 on the next edge; otherwise it holds its previous value.
REQ-019 Read and write in the same cycle: the read SHALL return the pre-write sel.
REQ-020 nib_q is the registered previous nib. joypad_irq SHALL be 1 for exactly the cycle after any bit of nib_q & ~nib is 1 (any 1->0 transition).
- Applies whether the cause is a debounced press or a sel write.
REQ-021 Releases (0->1 transitions) SHALL NOT generate an interrupt.
REQ-022 Multiple simultaneous falling bits SHALL produce a single pulse; falls on consecutive cycles produce consecutive pulses.
REQ-023 A btn glitch shorter than DEBOUNCE_CYCLES cycles SHALL change neither db nor any output.

Reset
REQ-024 While rst == 0, all state clears asynchronously:
- synchronizers = 0, db = 0, counters = 0
- sel = 2'b11
- nib_q = 4'hF
- bus_rdata = 8'hFF
- joypad_irq = 0
REQ-025 Reset asserted mid-debounce SHALL discard the partial count.
REQ-026 After reset release, no interrupt SHALL fire unless a new 1->0 transition of nib occurs.

Verification
REQ-027 Reset, then read 0xFF00 -> bus_rdata = 8'hFF one cycle after bus_re; joypad_irq stays 0.
REQ-028 Write 8'h20 (sel = 2'b10, directions selected); hold btn = 8'h04 (up) steady -> joypad_irq pulses exactly once, 2 + DEBOUNCE_CYCLES (+/-1) cycles after btn rises; a subsequent read returns 8'hEB.
REQ-029 sel = 2'b10; pulse btn[0] high for DEBOUNCE_CYCLES/2 cycles -> no irq; reads stay 8'hEF.
REQ-030 Hold btn = 8'h80 (start, debounced) with sel = 2'b11 -> no irq. Write 8'h10 (sel = 2'b01) -> irq pulses once, 2 cycles after the write strobe; read returns 8'hD7.
REQ-031 sel = 2'b00; hold btn = 8'h11 (A + right) -> a single irq pulse and read 8'hCE. Release both -> no irq; read returns 8'hCF.
REQ-032 Assert rst low midway through a debounce count, then release and keep btn stable -> the full DEBOUNCE_CYCLES delay restarts, and bus_rdata reads 8'hFF immediately after reset.

Source files
------------

// File: rtl/mmio_joypad_ctrl.sv
// P1 (0xFF00) joypad register: synchronised, per-button debounced inputs, group select, press interrupt.
// Read data lands one cycle after the read strobe; there is no backpressure and accesses always complete.
module mmio_joypad_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  input  logic       bus_sel,
  input  logic       bus_we,
  input  logic       bus_re,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       joypad_irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]          sync1_q, sync2_q;
  logic [7:0]          db_q, db_d;
  logic [7:0][CW-1:0]  cnt_q, cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [3:0]          nib, nib_q;
  logic [7:0]          p1;
  logic [7:0]          rdata_q, rdata_d;
  logic                irq_q, irq_d;
  logic                unused_wdata;

  assign unused_wdata = ^{bus_wdata[7:6], bus_wdata[3:0]};

  // A counter only advances while its button disagrees with the accepted state,
  // and is cleared on acceptance, so it tops out at CNT_LAST and never wraps.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 8; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    nib = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (!sel_q[0] && db_q[k])     nib[k] = 1'b0;
      if (!sel_q[1] && db_q[k + 4]) nib[k] = 1'b0;
    end
  end

  assign p1 = {2'b11, sel_q, nib};

  // A read in the same cycle as a write sees the old select, since p1 uses sel_q.
  always_comb begin
    sel_d   = (bus_sel && bus_we) ? bus_wdata[5:4] : sel_q;
    rdata_d = (bus_sel && bus_re) ? p1 : rdata_q;
    irq_d   = |(nib_q & ~nib);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      sel_q   <= 2'b11;
      nib_q   <= 4'hF;
      rdata_q <= 8'hFF;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      nib_q   <= nib;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign joypad_irq = irq_q;

endmodule
